// File: rtl/dmem_bytelane.sv
// Byte-lane data memory for the RV32 load/store path: registered 1-cycle read,
// sized/extended loads, lane-masked stores, fault detection and a post-reset clear sweep.
module dmem_bytelane #(
    parameter int DEPTH     = 256,
    parameter int DEBUG_IDX = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    input  logic        req_write_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        req_ready_o,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_fault_o,
    output logic [31:0] debug_word_o
);
    localparam int             AW   = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    localparam logic [AW-1:0] DBG  = AW'(DEBUG_IDX);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_fault_q, rsp_fault_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;

    logic [31:0]   mem_q [DEPTH];

    logic          accept, oob, misal, fault;
    logic [AW-1:0] idx;
    logic [31:0]   rd_word, rd_shift, load_data, st_data;
    logic [3:0]    st_be;

    logic          wr_en;
    logic [AW-1:0] wr_idx;
    logic [31:0]   wr_data;
    logic [3:0]    wr_be;

    assign accept = req_valid_i && (state_q == RUN);
    assign idx    = req_addr_i[AW+1:2];
    // Any index bit above the array range faults rather than aliasing a low word.
    assign oob    = |req_addr_i[31:AW+2];
    assign misal  = ((req_size_i == 2'd1) && req_addr_i[0]) ||
                    ((req_size_i == 2'd2) && (req_addr_i[1:0] != 2'b00));
    assign fault  = (req_size_i == 2'd3) || misal || oob;

    assign rd_word  = mem_q[idx];
    // One shifter serves both byte and half extraction since legal halves have addr[0]=0.
    assign rd_shift = rd_word >> {req_addr_i[1:0], 3'b000};

    always_comb begin
        load_data = rd_word;
        st_data   = req_wdata_i;
        st_be     = 4'hF;
        case (req_size_i)
            2'd0: begin
                load_data = req_unsigned_i ? {24'b0, rd_shift[7:0]}
                                           : {{24{rd_shift[7]}}, rd_shift[7:0]};
                st_data   = {4{req_wdata_i[7:0]}};
                st_be     = 4'b0001 << req_addr_i[1:0];
            end
            2'd1: begin
                load_data = req_unsigned_i ? {16'b0, rd_shift[15:0]}
                                           : {{16{rd_shift[15]}}, rd_shift[15:0]};
                st_data   = {2{req_wdata_i[15:0]}};
                st_be     = req_addr_i[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;
        rsp_fault_d = 1'b0;
        rsp_rdata_d = 32'b0;
        wr_en       = 1'b0;
        wr_idx      = idx;
        wr_data     = st_data;
        wr_be       = st_be;
        case (state_q)
            CLEAR: begin
                wr_en   = 1'b1;
                wr_idx  = cnt_q;
                wr_data = 32'b0;
                wr_be   = 4'hF;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = RUN;
            end
            RUN: begin
                if (accept) begin
                    rsp_valid_d = 1'b1;
                    rsp_fault_d = fault;
                    if (!fault) begin
                        if (req_write_i) wr_en = 1'b1;
                        else             rsp_rdata_d = load_data;
                    end
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CLEAR;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_fault_q <= 1'b0;
            rsp_rdata_q <= 32'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_fault_q <= rsp_fault_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // The array itself is not reset; the sweep clears it so debug_word_o holds until swept.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            for (int l = 0; l < 4; l++) begin
                if (wr_be[l]) mem_q[wr_idx][8*l +: 8] <= wr_data[8*l +: 8];
            end
        end
    end

    assign req_ready_o  = (state_q == RUN);
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_fault_o  = rsp_fault_q;
    assign rsp_rdata_o  = rsp_rdata_q;
    assign debug_word_o = mem_q[DBG];

endmodule

// File: tb/tb_dmem_bytelane.sv
// Scoreboard bench for dmem_bytelane: expected responses queued at issue, checked on rsp_valid_o.
module tb_dmem_bytelane;
    localparam int DEPTH = 16;
    localparam int DBG   = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_write_i = 1'b0;
    logic [1:0]  req_size_i = 2'd0;
    logic        req_unsigned_i = 1'b0;
    logic [31:0] req_addr_i = 32'b0;
    logic [31:0] req_wdata_i = 32'b0;
    logic        req_ready_o, rsp_valid_o, rsp_fault_o;
    logic [31:0] rsp_rdata_o, debug_word_o;

    dmem_bytelane #(.DEPTH(DEPTH), .DEBUG_IDX(DBG)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_write_i(req_write_i), .req_size_i(req_size_i),
        .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .req_ready_o(req_ready_o), .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
        .rsp_fault_o(rsp_fault_o), .debug_word_o(debug_word_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fault;
        logic [31:0] data;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    always @(negedge clk) begin
        if (rsp_valid_o === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_rsp: got fault=%0b data=%08h, none expected",
                         rsp_fault_o, rsp_rdata_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({rsp_fault_o, rsp_rdata_o} !== {e.fault, e.data}) begin
                    miscompares++;
                    $display("FAIL %s: got fault=%0b data=%08h, expected fault=%0b data=%08h",
                             e.name, rsp_fault_o, rsp_rdata_o, e.fault, e.data);
                end
            end
        end
    end

    task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic ef, input logic [31:0] ed, input string nm);
        exp_t e;
        @(negedge clk);
        req_valid_i = 1'b1; req_write_i = wr; req_size_i = sz;
        req_unsigned_i = uns; req_addr_i = addr; req_wdata_i = wd;
        e.fault = ef; e.data = ed; e.name = nm;
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            req_valid_i = 1'b0;
        end
    endtask

    task automatic drain(input string nm);
        idle(3);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_drain: %0d responses outstanding, expected 0", nm, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Called at a negedge with rst low; returns at the negedge where ready is first seen.
    task automatic wait_ready(output int n);
        n = 0;
        while (n < 4*DEPTH) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (req_ready_o === 1'b1) break;
        end
    endtask

    task automatic test_reset();
        int n;
        @(negedge clk);
        rst = 1'b1;
        req_valid_i = 1'b1; req_write_i = 1'b0; req_size_i = 2'd2; req_addr_i = 32'h0;
        @(negedge clk);
        vectors += 4;
        if (req_ready_o !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %0b, expected 0", req_ready_o); end
        if (rsp_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %0b, expected 0", rsp_valid_o); end
        if (rsp_rdata_o !== 32'h0) begin miscompares++; $display("FAIL reset_rdata: got %08h, expected 0", rsp_rdata_o); end
        if (rsp_fault_o !== 1'b0) begin miscompares++; $display("FAIL reset_fault: got %0b, expected 0", rsp_fault_o); end
        rst = 1'b0;
        // req_valid_i stays high through the sweep; any response here is flagged as unexpected.
        wait_ready(n);
        req_valid_i = 1'b0;
        vectors++;
        if (n !== DEPTH) begin miscompares++; $display("FAIL reset_sweep_len: got %0d cycles, expected %0d", n, DEPTH); end
    endtask

    task automatic test_sweep_zero();
        for (int i = 0; i < DEPTH; i++) issue(1'b0, 2'd2, 1'b0, 32'(i*4), 32'h0, 1'b0, 32'h0, "sweep_zero");
        drain("sweep_zero");
    endtask

    task automatic test_word_byte();
        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, 1'b0, 32'h0, "st_word");
        issue(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 1'b0, 32'h00000033, "ld_byte_s_11");
        issue(1'b0, 2'd0, 1'b1, 32'h11, 32'h0, 1'b0, 32'h00000033, "ld_byte_u_11");
        issue(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 1'b0, 32'h00001122, "ld_half_12");
        issue(1'b0, 2'd1, 1'b0, 32'h10, 32'h0, 1'b0, 32'h00003344, "ld_half_10");
        drain("word_byte");
    endtask

    task automatic test_byte_store();
        issue(1'b1, 2'd0, 1'b0, 32'h13, 32'hAAAAAAF0, 1'b0, 32'h0, "st_byte_13");
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, 32'hF0223344, "ld_word_10");
        issue(1'b0, 2'd2, 1'b1, 32'h10, 32'h0, 1'b0, 32'hF0223344, "ld_word_u_10");
        issue(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 1'b0, 32'hFFFFFFF0, "ld_byte_s_13");
        issue(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 1'b0, 32'h000000F0, "ld_byte_u_13");
        issue(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 1'b0, 32'hFFFFF022, "ld_half_s_12");
        drain("byte_store");
    endtask

    task automatic test_back_to_back();
        issue(1'b1, 2'd1, 1'b0, 32'h22, 32'h1234BEEF, 1'b0, 32'h0, "st_half_22");
        issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b0, 32'hBEEF0000, "b2b_ld_word_20");
        issue(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 1'b0, 32'hFFFFBEEF, "b2b_ld_half_s_22");
        issue(1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 1'b0, 32'h0000BEEF, "b2b_ld_half_u_22");
        issue(1'b0, 2'd0, 1'b0, 32'h20, 32'h0, 1'b0, 32'h00000000, "b2b_ld_byte_20");
        drain("back_to_back");
    endtask

    task automatic test_faults();
        issue(1'b1, 2'd1, 1'b0, 32'h1, 32'hFFFFFFFF, 1'b1, 32'h0, "flt_st_half_1");
        issue(1'b1, 2'd2, 1'b0, 32'h2, 32'hFFFFFFFF, 1'b1, 32'h0, "flt_st_word_2");
        issue(1'b1, 2'd3, 1'b0, 32'h0, 32'hFFFFFFFF, 1'b1, 32'h0, "flt_st_size3");
        issue(1'b1, 2'd2, 1'b0, 32'(4*DEPTH), 32'hFFFFFFFF, 1'b1, 32'h0, "flt_st_oob");
        issue(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 1'b1, 32'h0, "flt_ld_size3");
        issue(1'b0, 2'd1, 1'b0, 32'h11, 32'h0, 1'b1, 32'h0, "flt_ld_half_11");
        issue(1'b0, 2'd2, 1'b0, 32'h80000010, 32'h0, 1'b1, 32'h0, "flt_ld_oob_hi");
        issue(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, "flt_reload_0");
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, 32'hF0223344, "flt_reload_10");
        drain("faults");
    endtask

    task automatic test_debug();
        idle(1);
        vectors++;
        if (debug_word_o !== 32'h0) begin miscompares++; $display("FAIL debug_pre: got %08h, expected 0", debug_word_o); end
        issue(1'b1, 2'd2, 1'b0, 32'(DBG*4), 32'hDEADBEEF, 1'b0, 32'h0, "st_debug");
        idle(1);
        vectors++;
        if (debug_word_o !== 32'hDEADBEEF) begin miscompares++; $display("FAIL debug_post: got %08h, expected deadbeef", debug_word_o); end
        drain("debug");
    endtask

    task automatic test_reset_mid();
        int n;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        vectors++;
        if (debug_word_o !== 32'hDEADBEEF) begin miscompares++; $display("FAIL mid_sweep_debug_hold: got %08h, expected deadbeef", debug_word_o); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_ready(n);
        vectors += 2;
        if (n !== DEPTH) begin miscompares++; $display("FAIL mid_sweep_len: got %0d cycles, expected %0d", n, DEPTH); end
        if (debug_word_o !== 32'h0) begin miscompares++; $display("FAIL mid_sweep_debug_clr: got %08h, expected 0", debug_word_o); end
        issue(1'b1, 2'd2, 1'b0, 32'h8, 32'hCAFEF00D, 1'b0, 32'h0, "st_pre_rst");
        issue(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 1'b0, 32'hCAFEF00D, "ld_pre_rst");
        // Reset lands while that response is on the bus and a second load is presented.
        @(negedge clk);
        rst = 1'b1;
        req_valid_i = 1'b1; req_write_i = 1'b0; req_size_i = 2'd2; req_addr_i = 32'h8;
        @(negedge clk);
        rst = 1'b0;
        req_valid_i = 1'b0;
        vectors++;
        if (rsp_valid_o !== 1'b0) begin miscompares++; $display("FAIL mid_rsp_drop: got %0b, expected 0", rsp_valid_o); end
        wait_ready(n);
        vectors++;
        if (n !== DEPTH) begin miscompares++; $display("FAIL mid_rsp_sweep_len: got %0d cycles, expected %0d", n, DEPTH); end
        issue(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 1'b0, 32'h0, "ld_post_rst");
        drain("reset_mid");
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        test_sweep_zero();
        test_word_byte();
        test_byte_store();
        test_back_to_back();
        test_faults();
        test_debug();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
